// File: rtl/spi_reg_bank.sv
// ---------------------------------------------------------------------------
// spi_reg_bank
//
// SPI-slave register bank. Frames of {addr, data} arrive MSB first on slow,
// asynchronous SPI pins and are oversampled in the i_clk domain. A completed
// frame either writes its register directly or waits in a staging slot until
// a commit strobe. The commit strobe is typically vsync, so that consumers
// only ever see whole register sets change.
//
// Ports
//   i_clk        system clock; the only clock
//   i_reset      synchronous, active-high reset
//   i_sclk       SPI clock (async); MOSI is sampled on its rising edge
//   i_csb        SPI chip select (async), active low
//   i_mosi       SPI data (async), MSB first
//   i_immediate  1 = apply writes directly, 0 = stage until commit
//   i_commit     commit strobe, sampled every cycle (level-safe)
//   o_regs       live register file, register k at [k*REG_W +: REG_W]
//   o_pending    a staged write is waiting for commit
//   o_wr_strobe  one-cycle pulse when a register is written
//   o_wr_addr    address of the last applied write
//   o_frame_err  one-cycle pulse on a short frame or out-of-range address
// ---------------------------------------------------------------------------
module spi_reg_bank #(
    parameter int NUM_REGS    = 8,
    parameter int ADDR_W      = 3,
    parameter int REG_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter logic [NUM_REGS*REG_W-1:0] RESET_VAL = '0
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_sclk,
    input  logic                      i_csb,
    input  logic                      i_mosi,
    input  logic                      i_immediate,
    input  logic                      i_commit,
    output logic [NUM_REGS*REG_W-1:0] o_regs,
    output logic                      o_pending,
    output logic                      o_wr_strobe,
    output logic [ADDR_W-1:0]         o_wr_addr,
    output logic                      o_frame_err
);

    localparam int FRAME_W = ADDR_W + REG_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);

    // ------------------------------------------------------------------
    // Input synchronisers. All three pins go through the same depth so a
    // MOSI bit stays aligned with the SCLK rise that samples it.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] csb_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_prev;

    logic sclk_s;
    logic csb_s;
    logic mosi_s;
    logic sclk_rise;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign csb_s     = csb_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;

    // NOTE: every clocked block uses <= so all flops sample pre-edge values;
    // with = the chain would collapse into a single stage in simulation.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sclk_sync <= '0;
            csb_sync  <= '1;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_sclk};
            csb_sync  <= {csb_sync[SYNC_STAGES-2:0], i_csb};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_mosi};
            sclk_prev <= sclk_s;
        end
    end

    // ------------------------------------------------------------------
    // Frame receiver. The counter saturates at FRAME_W, so extra bits in
    // the same csb window are ignored and only one frame is accepted.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]   bit_cnt;
    logic [FRAME_W-2:0] shift_reg;
    logic [FRAME_W-1:0] frame_word;
    logic [ADDR_W-1:0]  frame_addr;
    logic [REG_W-1:0]   frame_data;
    logic               frame_done;
    logic               addr_ok;

    // Capture slot: a just-completed, address-checked frame plus the mode
    // that was selected when it completed.
    logic              cap_valid;
    logic              cap_imm;
    logic [ADDR_W-1:0] cap_addr;
    logic [REG_W-1:0]  cap_data;

    assign frame_word = {shift_reg, mosi_s};
    assign frame_addr = frame_word[FRAME_W-1 -: ADDR_W];
    assign frame_data = frame_word[REG_W-1:0];
    assign frame_done = sclk_rise & ~csb_s & (bit_cnt == CNT_LAST);
    assign addr_ok    = int'(frame_addr) < NUM_REGS;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            bit_cnt     <= '0;
            shift_reg   <= '0;
            cap_valid   <= 1'b0;
            cap_imm     <= 1'b0;
            cap_addr    <= '0;
            cap_data    <= '0;
            o_frame_err <= 1'b0;
        end else begin
            cap_valid   <= 1'b0;
            o_frame_err <= 1'b0;
            if (csb_s) begin
                // The counter is held at zero while csb is high, so a
                // non-zero, non-full count here means csb just rose early.
                bit_cnt <= '0;
                if (bit_cnt != '0 && bit_cnt != CNT_FULL) begin
                    o_frame_err <= 1'b1;
                end
            end else if (sclk_rise && bit_cnt != CNT_FULL) begin
                bit_cnt   <= bit_cnt + CNT_W'(1);
                shift_reg <= frame_word[FRAME_W-2:0];
                if (frame_done) begin
                    if (addr_ok) begin
                        cap_valid <= 1'b1;
                        cap_imm   <= i_immediate;
                        cap_addr  <= frame_addr;
                        cap_data  <= frame_data;
                    end else begin
                        o_frame_err <= 1'b1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Register file, staging slot and commit.
    // ------------------------------------------------------------------
    logic [REG_W-1:0]  regs [NUM_REGS];
    logic [ADDR_W-1:0] pend_addr;
    logic [REG_W-1:0]  pend_data;

    // NOTE: the register file is reset because it must come up holding
    // RESET_VAL; it is a small flop bank, not a RAM, so this is cheap.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs[k] <= RESET_VAL[k*REG_W +: REG_W];
            end
            pend_addr   <= '0;
            pend_data   <= '0;
            o_pending   <= 1'b0;
            o_wr_strobe <= 1'b0;
            o_wr_addr   <= '0;
        end else begin
            o_wr_strobe <= 1'b0;

            // The commit reads the old slot contents, so a frame arriving
            // on the same edge is staged behind it and o_pending stays set.
            if (i_commit && o_pending) begin
                regs[pend_addr] <= pend_data;
                o_wr_strobe     <= 1'b1;
                o_wr_addr       <= pend_addr;
                o_pending       <= 1'b0;
            end

            if (cap_valid) begin
                if (cap_imm) begin
                    // Direct writes bypass the staging slot, so a pending
                    // write survives a switch to immediate mode.
                    regs[cap_addr] <= cap_data;
                    o_wr_strobe    <= 1'b1;
                    o_wr_addr      <= cap_addr;
                end else begin
                    pend_addr <= cap_addr;
                    pend_data <= cap_data;
                    o_pending <= 1'b1;
                end
            end
        end
    end

    // NOTE: o_regs gets a full default before the loop so no path through
    // this block can leave a bit unassigned and infer a latch.
    always_comb begin
        o_regs = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            o_regs[k*REG_W +: REG_W] = regs[k];
        end
    end

endmodule

// File: doc/spi_reg_bank.md
Name: spi_reg_bank

Overview:
- Parametrised SPI-slave register bank: the next generation of the fixed LA-driven register/vector SPI loaders in the raybox top.
- Receives address+data frames over slow, asynchronous SPI pins (LA or GPIO) and holds NUM_REGS registers of REG_W bits each.
- Each write is applied either immediately or double-buffered, staged until a frame-boundary commit pulse (e.g. vsync), so the renderer never sees a half-updated register set mid-frame.

Parameters:
- NUM_REGS, 8: number of registers.
- ADDR_W, 3: address field width; NUM_REGS <= 2**ADDR_W.
- REG_W, 16: register and data field width.
- SYNC_STAGES, 2: flip-flop synchroniser depth on sclk, csb and mosi; minimum 2.
- RESET_VAL, 0: flat NUM_REGS*REG_W reset image; register k takes bits [k*REG_W +: REG_W].

Ports:
- i_clk  in  1  system clock; the only clock.
- i_reset  in  1  synchronous, active-high reset.
- i_sclk  in  1  SPI clock, asynchronous; MOSI is sampled on its rising edge.
- i_csb  in  1  SPI chip select, active-low, asynchronous.
- i_mosi  in  1  SPI data, MSB first, asynchronous.
- i_immediate  in  1  1 = apply writes directly; 0 = stage until commit.
- i_commit  in  1  commit strobe, sampled every cycle; level-safe.
- o_regs  out  NUM_REGS*REG_W  live register file, flat.
- o_pending  out  1  a staged write is waiting for commit.
- o_wr_strobe  out  1  one-cycle pulse when any register is written.
- o_wr_addr  out  ADDR_W  address of the last applied write.
- o_frame_err  out  1  one-cycle pulse on a malformed frame.

Behaviour:
- Reset state: o_regs=RESET_VAL, o_pending=0, o_wr_strobe=0, o_wr_addr=0, o_frame_err=0. The bit counter, shift register and staging slot are cleared. Synchroniser flops reset to sclk=0, csb=1, mosi=0.
- Reset mid-frame: the partial frame is discarded silently (no err pulse). A staged write is dropped.
- Synchronisation: a rising edge on i_sclk is detected SYNC_STAGES+1 cycles after the raw edge. i_mosi is synchronised through the same depth, so sample alignment is preserved.
- Frame format: FRAME_W = ADDR_W+REG_W bits, sent as address then data, MSB first.
- Bit counter: counts detected sclk rises while synchronised csb=0. It clears whenever synchronised csb=1.
- Frame complete: on the rise that takes the count to FRAME_W, {addr,data} is latched into the staging slot on that same clock edge.
  - If addr >= NUM_REGS: the frame is discarded and o_frame_err pulses on the next cycle.
- Extra bits: rises after the count reaches FRAME_W, within the same csb-low window, are ignored. Only one frame is accepted per csb assertion.
- Short frame: synchronised csb rises while 0 < count < FRAME_W -> o_frame_err pulses for 1 cycle; no write. If csb rises with count == 0 or count == FRAME_W, there is no error.
- Immediate mode (i_immediate=1): the register is written 1 cycle after the staging latch. o_wr_strobe pulses in that same cycle, o_wr_addr updates, and o_pending stays 0.
- Staged mode (i_immediate=0):
  - o_pending rises 1 cycle after the staging latch.
  - On a cycle with i_commit=1 and o_pending=1: register[addr] <= staged data, o_wr_strobe pulses the next cycle, o_pending clears.
  - i_commit with o_pending=0 has no effect.
- Overwrite: a new completed frame while o_pending=1 replaces the staging slot; only the last write is committed, and o_pending stays 1.
- Simultaneous commit and frame completion in the same cycle: the old staged value commits, the new frame is staged, and o_pending remains 1.
- Mode switch: i_immediate sampled at frame completion decides the path. If a write is pending when i_immediate goes 1, it stays pending until i_commit.
- Widths: no arithmetic; the counter is clog2(FRAME_W+1) bits and saturates at FRAME_W.

Test Plan:
- After reset, o_regs==RESET_VAL, o_pending=0 -> send addr=3, data=0xBEEF with i_immediate=1 -> reg3==0xBEEF, o_wr_strobe pulses once, o_wr_addr=3, other registers unchanged.
- With i_immediate=0, send addr=5, data=0x1234 -> o_pending=1 and reg5 unchanged. Pulse i_commit -> reg5==0x1234, o_pending=0, one o_wr_strobe.
- With i_immediate=0:
  - Send addr=1 data=0x0001, then addr=2 data=0x0002 before any commit -> a single commit writes only reg2=0x0002; reg1 is unchanged.
  - Repeat with i_commit held high for 5 cycles -> exactly one write.
- Send 10 of 19 bits then raise csb -> o_frame_err pulses once; no register changes; the next full frame to addr=0 succeeds.
- Send a 25-bit burst in one csb window -> only the first 19 bits apply. Then, with NUM_REGS=6, send addr=7 -> o_frame_err pulses and no write occurs.
- Assert i_reset after 12 bits, then deassert and send a full frame addr=4 data=0xA5A5 -> no err pulse from the aborted frame; reg4==0xA5A5.
